// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue: instruction prefetch FIFO between fetch and decode.
// Holds up to DEPTH {pc, instr} pairs. A flush (redirect) discards every entry.
// Optional macro IFQ_BYPASS_EN: when the queue is empty, the fetch word is
// forwarded to decode combinationally. If decode takes it in that cycle, the
// word is never stored.
module ifid_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [PC_W-1:0]          out_opcplus4,
    output logic [INST_W-1:0]        out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PC_W-1:0]   pc_mem    [DEPTH];
    logic [INST_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              not_full_q;
    logic              head_valid;
    logic              bypass_take;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count_nxt;

    // Handshake decode, head/bypass output select and next occupancy.
    always_comb begin
        in_ready    = not_full_q & ~reset;
        head_valid  = (count != '0);
        bypass_take = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (!head_valid && in_valid && in_ready && !flush) begin
            out_valid   = 1'b1;
            out_pc      = in_pc;
            out_instr   = in_instr;
            bypass_take = out_ready;
        end else begin
            out_valid   = head_valid;
            out_pc      = pc_mem[rd_ptr];
            out_instr   = instr_mem[rd_ptr];
        end
`else
        out_valid = head_valid;
        out_pc    = pc_mem[rd_ptr];
        out_instr = instr_mem[rd_ptr];
`endif
        out_opcplus4 = out_pc + PC_W'(4);
        push         = in_valid & in_ready & ~flush & ~bypass_take;
        pop          = head_valid & out_ready & ~flush;
        count_nxt    = flush ? '0 : (count + CW'(push) - CW'(pop));
    end

    // Pointers, occupancy and the registered not-full flag behind in_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_full_q <= 1'b1;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_full_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nxt;
            not_full_q <= (count_nxt < CW'(DEPTH));
        end
    end

    // Entry storage; cleared on reset so the outputs read zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Bench for ifid_fetch_queue (DEPTH=4, 32-bit PC/instr), default build.
module tb_ifid_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_opcplus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];
    int   mcount;
    logic mready;
    int   tests = 0;
    int   fails = 0;

    ifid_fetch_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcplus4(out_opcplus4), .out_instr(out_instr), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, apply this cycle's handshake, then clock.
    task automatic cycle();
        logic do_push;
        logic do_pop;
        ent_t h;
        chk("count", 64'(count), 64'(mcount));
        chk("out_valid", 64'(out_valid), 64'(mcount != 0));
        chk("in_ready", 64'(in_ready), 64'(mready));
        do_push = in_valid && mready && !flush;
        do_pop  = (mcount != 0) && out_ready && !flush;
        if (do_pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                h = sb.pop_front();
                chk("out_pc", 64'(out_pc), 64'(h.pc));
                chk("out_instr", 64'(out_instr), 64'(h.instr));
                chk("out_opcplus4", 64'(out_opcplus4), 64'(32'(h.pc + 32'd4)));
            end
        end
        if (flush) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (do_push) sb.push_back('{pc: in_pc, instr: in_instr});
            mcount = mcount + int'(do_push) - int'(do_pop);
        end
        mready = (mcount < 4);
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = 32'h0043_0820 + pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        mcount = 0;
        mready = 1'b0;

        // 1: reset for two cycles
        repeat (2) begin
            @(posedge clock);
            #1;
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_pc", 64'(out_pc), 64'(0));
            chk("rst_out_instr", 64'(out_instr), 64'(0));
        end
        reset  = 1'b0;
        mready = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // 2: fill to full, refuse fifth, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        chk("full_count", 64'(count), 64'(4));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        cycle();
        chk("refused_count", 64'(count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end
        chk("drained_count", 64'(count), 64'(0));

        // 3: pop while full does not enable a same-cycle push
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h50, 1'b1, 1'b0);
        cycle();
        chk("full_pop_count", 64'(count), 64'(3));
        chk("full_pop_in_ready", 64'(in_ready), 64'(1));
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        cycle();
        chk("refill_count", 64'(count), 64'(4));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end

        // 4: flush at count=3 drops queue and the offered word
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h60 + 32'(i * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h20, 1'b1, 1'b1);
        cycle();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            cycle();
        end

        // 5: streaming push+pop, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            cycle();
            if (i > 0) chk("stream_count", 64'(count), 64'(1));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();

        // PC+4 wraps at the top of the address space
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        cycle();
        chk("wrap_opcplus4", 64'(out_opcplus4), 64'(0));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();

        // 6: empty queue, word offered with decode ready
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("bypass_out_valid", 64'(out_valid), 64'(1));
        chk("bypass_out_pc", 64'(out_pc), 64'(32'h40));
        @(posedge clock);
        #1;
        chk("bypass_count", 64'(count), 64'(0));
`else
        chk("nobypass_out_valid", 64'(out_valid), 64'(0));
        cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle();
        chk("nobypass_final_count", 64'(count), 64'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
